// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM states, ALU selects and SKIPCOND condition codes for the
// accumulator CPU core.
package acc_cpu_pkg;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLoad  = 4'h1;
  localparam logic [3:0] OpStore = 4'h2;
  localparam logic [3:0] OpAdd   = 4'h3;
  localparam logic [3:0] OpSub   = 4'h4;
  localparam logic [3:0] OpAnd   = 4'h5;
  localparam logic [3:0] OpOr    = 4'h6;
  localparam logic [3:0] OpNot   = 4'h7;
  localparam logic [3:0] OpBack  = 4'h8;
  localparam logic [3:0] OpSkip  = 4'h9;
  localparam logic [3:0] OpJump  = 4'hA;
  localparam logic [3:0] OpClear = 4'hB;
  localparam logic [3:0] OpHalt  = 4'hF;

  typedef enum logic [3:0] {
    StIfAddr,
    StIfData,
    StDecode,
    StMemAddr,
    StMemData,
    StExec,
    StMemWrite,
    StHalt,
    StWaitStep
  } state_e;

  typedef enum logic [2:0] {
    AluPass,
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluNot
  } alu_sel_e;

  localparam logic [1:0] CondNeg   = 2'b00;
  localparam logic [1:0] CondZero  = 2'b01;
  localparam logic [1:0] CondPos   = 2'b10;
  localparam logic [1:0] CondNever = 2'b11;

  // Opcodes that fetch an operand word before executing.
  function automatic logic is_mem_read_op(logic [3:0] op);
    return (op == OpLoad) || (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr);
  endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Synchronous single-port RAM bus between the accumulator core (master) and
// the memory (slave).
interface acc_cpu_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_cs,
    output mem_we,
    output mem_oe,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_cs,
    input  mem_we,
    input  mem_oe,
    output mem_rdata
  );

endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: y = f(a, b) selected by sel; a is the
// accumulator, b the memory buffer word.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_sel_e              sel,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = b;
    unique case (sel)
      AluPass: y = b;
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluAnd:  y = a & b;
      AluOr:   y = a | b;
      AluNot:  y = ~a;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Single-accumulator CPU core: fetch/decode/execute over a synchronous RAM bus.
// Define ACC_CPU_STEP_EN to add the single-step input and WAIT_STEP state.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RESET_PC   = 'h100,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ACC_CPU_STEP_EN
  input  logic                  step,
`endif
  acc_cpu_if.master             mem,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  retired
);

`ifdef ACC_CPU_STEP_EN
  localparam state_e StStart = StWaitStep;
`else
  localparam state_e StStart = StIfAddr;
`endif

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] ac_q;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] mbr_q;
  logic                  halted_q;
  logic [CNT_WIDTH-1:0]  retired_q;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic [1:0]            cond;
  logic                  skip_take;
  logic                  retire;
  alu_sel_e              alu_sel;
  logic [DATA_WIDTH-1:0] alu_y;

  assign opcode  = ir_q[DATA_WIDTH-1 -: 4];
  assign operand = ir_q[ADDR_WIDTH-1:0];
  assign cond    = ir_q[DATA_WIDTH-5 -: 2];

  // Signed compares on the accumulator for SKIPCOND.
  always_comb begin
    skip_take = 1'b0;
    unique case (cond)
      CondNeg:  skip_take = ac_q[DATA_WIDTH-1];
      CondZero: skip_take = (ac_q == '0);
      CondPos:  skip_take = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
      default:  skip_take = 1'b0;
    endcase
  end

  always_comb begin
    unique case (opcode)
      OpAdd:   alu_sel = AluAdd;
      OpSub:   alu_sel = AluSub;
      OpAnd:   alu_sel = AluAnd;
      OpOr:    alu_sel = AluOr;
      OpNot:   alu_sel = AluNot;
      default: alu_sel = AluPass;
    endcase
  end

  acc_cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a  (ac_q),
    .b  (mbr_q),
    .sel(alu_sel),
    .y  (alu_y)
  );

  // An instruction retires in its last state; HALT retires on entry to StHalt.
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      StDecode:           retire = !(is_mem_read_op(opcode) || (opcode == OpStore));
      StExec, StMemWrite: retire = 1'b1;
      default:            retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StStart;
      pc_q      <= ADDR_WIDTH'(RESET_PC);
      ac_q      <= '0;
      ir_q      <= '0;
      mbr_q     <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (retire && !(&retired_q)) begin
        retired_q <= retired_q + CNT_WIDTH'(1);
      end
      unique case (state_q)
        StWaitStep: begin
`ifdef ACC_CPU_STEP_EN
          state_q <= step ? StIfAddr : StWaitStep;
`else
          state_q <= StIfAddr;
`endif
        end
        StIfAddr: state_q <= StIfData;
        StIfData: begin
          ir_q    <= mem.mem_rdata;
          state_q <= StDecode;
        end
        StDecode: begin
          pc_q    <= pc_q + ADDR_WIDTH'(1);
          state_q <= StStart;
          case (opcode)
            OpLoad, OpAdd, OpSub, OpAnd, OpOr: state_q <= StMemAddr;
            OpStore: state_q <= StMemWrite;
            OpHalt: begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end
            OpNot:   ac_q <= alu_y;
            OpBack:  pc_q <= pc_q - operand;
            OpSkip: begin
              if (skip_take) pc_q <= pc_q + ADDR_WIDTH'(2);
            end
            OpJump:  pc_q <= operand;
            OpClear: ac_q <= '0;
            default: ;
          endcase
        end
        StMemAddr: state_q <= StMemData;
        StMemData: begin
          mbr_q   <= mem.mem_rdata;
          state_q <= StExec;
        end
        StExec: begin
          ac_q    <= alu_y;
          state_q <= StStart;
        end
        StMemWrite: state_q <= StStart;
        StHalt:     state_q <= StHalt;
        default:    state_q <= StStart;
      endcase
    end
  end

  // Bus strobes decode the state register; rst masks them so a reset landing
  // on MEM_WRITE never writes.
  always_comb begin
    mem.mem_addr  = pc_q;
    mem.mem_wdata = ac_q;
    mem.mem_cs    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_oe    = 1'b0;
    unique case (state_q)
      StIfAddr: begin
        mem.mem_cs = 1'b1;
        mem.mem_oe = 1'b1;
      end
      StMemAddr: begin
        mem.mem_addr = operand;
        mem.mem_cs   = 1'b1;
        mem.mem_oe   = 1'b1;
      end
      StMemWrite: begin
        mem.mem_addr = operand;
        mem.mem_cs   = 1'b1;
        mem.mem_we   = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem.mem_cs = 1'b0;
      mem.mem_we = 1'b0;
      mem.mem_oe = 1'b0;
    end
  end

  assign pc      = pc_q;
  assign ac      = ac_q;
  assign ir      = ir_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed programs plus random straight-line programs
// compared against an instruction-level reference model.
module tb_acc_cpu_core;

`ifdef ACC_CPU_STEP_EN
  localparam int StepExtra = 1;
`else
  localparam int StepExtra = 0;
`endif
  localparam int MaxCycles = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pc;
  logic [15:0] ac;
  logic [15:0] ir;
  logic        halted;
  logic [31:0] retired;
`ifdef ACC_CPU_STEP_EN
  logic        step = 1'b1;
`endif

  logic        clr   = 1'b0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] ram [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  acc_cpu_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus ();

  acc_cpu_core dut (
    .clk    (clk),
    .rst    (rst),
`ifdef ACC_CPU_STEP_EN
    .step   (step),
`endif
    .mem    (bus),
    .pc     (pc),
    .ac     (ac),
    .ir     (ir),
    .halted (halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with a bench-side load port.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
    end else if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (bus.mem_cs && bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_cs && bus.mem_oe) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [15:0] m_mem [0:4095];
  int          m_trace[$];
  int          m_cyc, m_ret, m_pc;
  logic [15:0] m_ac;
  int          d_trace[$];

  task automatic model_run();
    int pc_i, ir_i, op, opd, nxt, lat;
    logic [15:0] acc;
    bit done, take;
    m_trace.delete();
    acc = 0; pc_i = 'h100; m_cyc = 0; m_ret = 0; done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      ir_i = int'(m_mem[pc_i]);
      op   = ir_i / 4096;
      opd  = ir_i % 4096;
      nxt  = (pc_i + 1) % 4096;
      lat  = 3;
      case (op)
        1:  begin acc = m_mem[opd]; lat = 6; end
        2:  begin m_mem[opd] = acc; lat = 4; end
        3:  begin acc = acc + m_mem[opd]; lat = 6; end
        4:  begin acc = acc - m_mem[opd]; lat = 6; end
        5:  begin acc = acc & m_mem[opd]; lat = 6; end
        6:  begin acc = acc | m_mem[opd]; lat = 6; end
        7:  acc = ~acc;
        8:  nxt = (pc_i - opd + 4096) % 4096;
        9:  begin
          case ((ir_i / 1024) % 4)
            0: take = $signed(acc) < 0;
            1: take = acc == 0;
            2: take = $signed(acc) > 0;
            default: take = 0;
          endcase
          if (take) nxt = (pc_i + 2) % 4096;
        end
        10: nxt = opd;
        11: acc = 0;
        15: done = 1;
        default: ;
      endcase
      pc_i = nxt;
      m_cyc += lat + StepExtra;
      m_ret++;
      m_trace.push_back(pc_i);
    end
    m_ac = acc; m_pc = pc_i;
  endtask

  task automatic begin_test();
    rst = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4096; i++) m_mem[i] = '0;
  endtask

  task automatic put(input int a, input int d);
    ld_addr = 12'(a);
    ld_data = 16'(d);
    ld_en   = 1'b1;
    m_mem[a] = 16'(d);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Runs from the current negedge until halted; records pc at each retirement.
  task automatic run_to_halt(output int cyc);
    logic [31:0] prev;
    cyc = 0;
    prev = retired;
    d_trace.delete();
    while (!halted && cyc < MaxCycles) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (retired != prev) begin
        d_trace.push_back(int'(pc));
        prev = retired;
      end
    end
    if (cyc >= MaxCycles) check("halt_timeout", 64'(cyc), 64'(0));
  endtask

  task automatic compare_model(input string tag, input int cyc, input int lo, input int hi);
    int n;
    check({tag, "_cycles"}, 64'(cyc), 64'(m_cyc));
    check({tag, "_ac"}, 64'(ac), 64'(m_ac));
    check({tag, "_pc"}, 64'(pc), 64'(m_pc));
    check({tag, "_retired"}, 64'(retired), 64'(m_ret));
    check({tag, "_trace_len"}, 64'(d_trace.size()), 64'(m_trace.size()));
    n = (d_trace.size() < m_trace.size()) ? d_trace.size() : m_trace.size();
    for (int i = 0; i < n; i++) check({tag, "_trace_pc"}, 64'(d_trace[i]), 64'(m_trace[i]));
    for (int a = lo; a <= hi; a++) check({tag, "_mem"}, 64'(ram[a]), 64'(m_mem[a]));
  endtask

  int cyc;
  int busy;

  initial begin
    repeat (2) @(negedge clk);

    // Reset values and add/store program.
    begin_test();
    check("cs_in_rst", 64'(bus.mem_cs), 64'(0));
    put('h100, 'h1110); put('h101, 'h3111); put('h102, 'h2112); put('h103, 'hF000);
    put('h110, 7); put('h111, 5);
    rst = 1'b0;
    #1;
    check("rst_pc", 64'(pc), 64'('h100));
    check("rst_ac", 64'(ac), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_retired", 64'(retired), 64'(0));
    check("first_addr", 64'(bus.mem_addr), 64'('h100));
    check("first_cs", 64'(bus.mem_cs), 64'(1 - StepExtra));
    check("first_oe", 64'(bus.mem_oe), 64'(1 - StepExtra));
    model_run();
    run_to_halt(cyc);
    check("add_halt_cycle", 64'(cyc), 64'(19 + 4 * StepExtra));
    check("add_store_word", 64'(ram['h112]), 64'('h000C));
    check("add_ac", 64'(ac), 64'('h000C));
    check("add_retired", 64'(retired), 64'(4));
    compare_model("add", cyc, 'h110, 'h112);
    busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      busy += int'(bus.mem_cs);
    end
    check("halt_no_access", 64'(busy), 64'(0));

    // Signed skip: 3 - 5 is negative, so CLEAR is skipped.
    begin_test();
    put('h100, 'h1110); put('h101, 'h4111); put('h102, 'h9000); put('h103, 'hB000);
    put('h104, 'hF000); put('h110, 3); put('h111, 5);
    rst = 1'b0;
    model_run();
    run_to_halt(cyc);
    check("skip_ac", 64'(ac), 64'('hFFFE));
    check("skip_pc", 64'(pc), 64'('h105));
    compare_model("skip", cyc, 'h110, 'h111);

    // Jump, back, wrap past 0xFFF.
    begin_test();
    put('h100, 'hA202); put('h202, 'h8002); put('h200, 'hAFFF); put('hFFF, 'h7000);
    put('h000, 'hF000);
    rst = 1'b0;
    model_run();
    run_to_halt(cyc);
    check("flow_jump", 64'((d_trace.size() > 0) ? d_trace[0] : -1), 64'('h202));
    check("flow_back", 64'((d_trace.size() > 1) ? d_trace[1] : -1), 64'('h200));
    check("flow_wrap", 64'((d_trace.size() > 3) ? d_trace[3] : -1), 64'('h000));
    check("flow_ac", 64'(ac), 64'('hFFFF));
    compare_model("flow", cyc, 0, 0);

    // Reset landing on the MEM_WRITE cycle.
    begin_test();
    put('h100, 'h1110); put('h101, 'h2112); put('h102, 'hF000);
    put('h110, 7); put('h112, 'h55);
    rst = 1'b0;
    repeat (9 + 2 * StepExtra) @(negedge clk);
    check("mid_we_before", 64'(bus.mem_we), 64'(1));
    check("mid_retired_before", 64'(retired), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_we_in_rst", 64'(bus.mem_we), 64'(0));
    @(negedge clk);
    check("mid_word_kept", 64'(ram['h112]), 64'('h55));
    check("mid_retired_after", 64'(retired), 64'(0));
    check("mid_pc_after", 64'(pc), 64'('h100));
    rst = 1'b0;
    #1;
    check("mid_restart_addr", 64'(bus.mem_addr), 64'('h100));
    model_run();
    run_to_halt(cyc);
    compare_model("mid", cyc, 'h110, 'h112);

    // Random straight-line programs over a 16-word data window.
    for (int t = 0; t < 8; t++) begin
      int ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11, 12};
      int op, w;
      begin_test();
      for (int a = 'h300; a < 'h310; a++) begin
        case ($urandom_range(0, 3))
          0: put(a, 0);
          1: put(a, 'h8000);
          2: put(a, 'h7FFF);
          default: put(a, int'($urandom_range(0, 65535)));
        endcase
      end
      for (int i = 0; i < 12; i++) begin
        op = ops[$urandom_range(0, 10)];
        if (op >= 1 && op <= 6) w = op * 4096 + 'h300 + int'($urandom_range(0, 15));
        else if (op == 9) w = 'h9000 + int'($urandom_range(0, 3)) * 1024;
        else w = op * 4096 + int'($urandom_range(0, 4095));
        put('h100 + i, w);
      end
      put('h10C, 'hF000); put('h10D, 'hF000);
      rst = 1'b0;
      model_run();
      run_to_halt(cyc);
      compare_model("rand", cyc, 'h300, 'h30F);
    end

`ifdef ACC_CPU_STEP_EN
    // Step gating: idle with step low, then exactly three single-cycle pulses.
    begin_test();
    put('h100, 'h1110); put('h101, 'h3111); put('h102, 'h2112); put('h103, 'hF000);
    put('h110, 7); put('h111, 5);
    step = 1'b0;
    rst = 1'b0;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      busy += int'(bus.mem_cs);
    end
    check("step_idle_access", 64'(busy), 64'(0));
    check("step_idle_retired", 64'(retired), 64'(0));
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (10) @(negedge clk);
    end
    check("step_retired", 64'(retired), 64'(3));
    check("step_ac", 64'(ac), 64'('h000C));
    check("step_store", 64'(ram['h112]), 64'('h000C));
    check("step_halted", 64'(halted), 64'(0));
    step = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
